dmem_responder: RTL and testbench

- Multi-cycle data-memory responder at the far end of the Y86 memory-stage interface.
- The memory stage (address, data, read and write select logic) is the initiator; this block accepts its read/write requests over a valid/ready handshake.
- Each request is serviced after a fixed latency. The block returns valM plus dmem_error, which feeds STAT.
- Replaces the zero-latency memory, so the pipeline can be tested against a realistic stalling memory.

---
 rtl/dmem_responder_pkg.sv | 10 +
 rtl/dmem_array.sv | 20 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default word width and FSM encodings.
package dmem_responder_pkg;
    localparam int DATA_WID = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_WID storage with write enable and registered read; contents are never reset.
module dmem_array #(
    parameter int DATA_WID = 8,
    parameter int MEM_AW   = 6,
    parameter int DEPTH    = 64
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [MEM_AW-1:0]   addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata
);
    logic [DATA_WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder behind a valid/ready request/response handshake.
// Define DMEM_PERF_CNT_EN to add saturating read/write/error response counters.
module dmem_responder #(
    parameter int DATA_WID = dmem_responder_pkg::DATA_WID,
    parameter int MEM_AW   = 6,
    parameter int DEPTH    = 64,
    parameter int LAT      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_WID-1:0] req_addr,
    input  logic [DATA_WID-1:0] req_wdata,
    input  logic                req_read,
    input  logic                req_write,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_WID-1:0] valM,
`ifdef DMEM_PERF_CNT_EN
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         err_cnt,
`endif
    output logic                dmem_error
);
    import dmem_responder_pkg::*;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [DATA_WID-1:0] l_addr, l_wdata, c_addr, c_wdata, rdata;
    logic                l_rd, l_wr, c_rd, c_wr, c_err;
    logic                accept, commit, handshake, we, re, err_q, rd_hit;

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign handshake = rsp_valid && rsp_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_nxt   = CW'(LAT - 1);
                state_nxt = (LAT == 1) ? RESP : BUSY;
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt_nxt == '0) state_nxt = RESP;
            end
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LAT==1 the commit edge is the acceptance edge, so use the live request.
    assign c_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign c_wdata = (state == IDLE) ? req_wdata : l_wdata;
    assign c_rd    = (state == IDLE) ? req_read  : l_rd;
    assign c_wr    = (state == IDLE) ? req_write : l_wr;

    assign commit = (state_nxt == RESP) && (state != RESP);
    assign c_err  = ({1'b0, c_addr} >= (DATA_WID+1)'(DEPTH)) || (c_rd && c_wr);
    assign we     = commit && c_wr && !c_err;
    assign re     = commit && c_rd && !c_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            l_rd    <= 1'b0;
            l_wr    <= 1'b0;
            err_q   <= 1'b0;
            rd_hit  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_rd    <= req_read;
                l_wr    <= req_write;
            end
            if (commit) begin
                err_q  <= c_err;
                rd_hit <= re;
            end else if (handshake) begin
                err_q  <= 1'b0;
                rd_hit <= 1'b0;
            end
        end
    end

    dmem_array #(.DATA_WID(DATA_WID), .MEM_AW(MEM_AW), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (c_addr[MEM_AW-1:0]),
        .wdata (c_wdata),
        .rdata (rdata)
    );

    // Array read register is not reset; gate it so non-read responses return zero.
    assign valM       = rd_hit ? rdata : '0;
    assign dmem_error = err_q;

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (handshake) begin
            if (err_q) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (l_rd) begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end else if (l_wr) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LAT=2 responder for function/backpressure/errors/reset, LAT=1 responder for latency and counters.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       req_valid = 0, req_read = 0, req_write = 0, rsp_ready = 0;
    logic [7:0] req_addr = 0, req_wdata = 0;
    logic       req_ready, rsp_valid, dmem_error;
    logic [7:0] valM;

    logic       req_valid1 = 0, req_read1 = 0, req_write1 = 0, rsp_ready1 = 0;
    logic [7:0] req_addr1 = 0, req_wdata1 = 0;
    logic       req_ready1, rsp_valid1, dmem_error1;
    logic [7:0] valM1;
`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_cnt0, wr_cnt0, err_cnt0, rd_cnt1, wr_cnt1, err_cnt1;
`endif

    dmem_responder #(.DATA_WID(8), .MEM_AW(6), .DEPTH(64), .LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_read(req_read), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .valM(valM),
`ifdef DMEM_PERF_CNT_EN
        .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0), .err_cnt(err_cnt0),
`endif
        .dmem_error(dmem_error)
    );

    dmem_responder #(.DATA_WID(8), .MEM_AW(6), .DEPTH(64), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_read(req_read1), .req_write(req_write1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .valM(valM1),
`ifdef DMEM_PERF_CNT_EN
        .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .err_cnt(err_cnt1),
`endif
        .dmem_error(dmem_error1)
    );

    // Present a request until accepted; returns #1 after the accepting edge, inputs scrambled.
    task automatic do_req(input logic [7:0] a, input logic [7:0] w, input logic rd, input logic wr);
        bit acc = 0;
        req_addr = a; req_wdata = w; req_read = rd; req_write = wr; req_valid = 1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 0; req_addr = 8'hFF; req_wdata = 8'h00; req_read = 1; req_write = 1;
        checks++;
        if (!acc) begin errors++; $display("FAIL accept_timeout addr=%h got no acceptance, need acceptance", a); end
    endtask

    task automatic wait_rsp(output logic [7:0] v, output logic e);
        bit got = 0;
        v = 8'h00; e = 1'b0; rsp_ready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin v = valM; e = dmem_error; got = 1; end
            @(posedge clk); #1;
        end
        rsp_ready = 0;
        checks++;
        if (!got) begin errors++; $display("FAIL rsp_timeout got no rsp_valid, need rsp_valid"); end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] w, input logic rd, input logic wr,
                       output logic [7:0] v, output logic e);
        do_req(a, w, rd, wr);
        wait_rsp(v, e);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== 0 || rsp_valid !== 0 || valM !== 8'h00 || dmem_error !== 0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b valM=%h err=%b, need 0 0 00 0", req_ready, rsp_valid, valM, dmem_error);
        end
        checks++;
        if (req_ready1 !== 0 || rsp_valid1 !== 0 || valM1 !== 8'h00 || dmem_error1 !== 0) begin
            errors++;
            $display("FAIL reset_state1 got rdy=%b vld=%b valM=%h err=%b, need 0 0 00 0", req_ready1, rsp_valid1, valM1, dmem_error1);
        end
`ifdef DMEM_PERF_CNT_EN
        checks++;
        if (rd_cnt1 !== 0 || wr_cnt1 !== 0 || err_cnt1 !== 0) begin
            errors++; $display("FAIL reset_cnt got %0d %0d %0d, need 0 0 0", rd_cnt1, wr_cnt1, err_cnt1);
        end
`endif
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1) begin errors++; $display("FAIL idle_ready got %b, need 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [7:0] v; logic e;
        do_req(8'h05, 8'h55, 0, 1);
        checks++;
        if (rsp_valid !== 0) begin errors++; $display("FAIL wr_early_rsp got %b, need 0", rsp_valid); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1 || dmem_error !== 0 || valM !== 8'h00) begin
            errors++; $display("FAIL wr_rsp_t2 got vld=%b err=%b valM=%h, need 1 0 00", rsp_valid, dmem_error, valM);
        end
        rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
        checks++;
        if (rsp_valid !== 0 || req_ready !== 1) begin
            errors++; $display("FAIL wr_handshake got vld=%b rdy=%b, need 0 1", rsp_valid, req_ready);
        end
        txn(8'h05, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h55 || e !== 0) begin errors++; $display("FAIL rd_05 got %h/%b, need 55/0", v, e); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v; logic e;
        txn(8'h03, 8'h33, 0, 1, v, e);
        do_req(8'h03, 8'h00, 1, 0);
        @(posedge clk); #1;
        req_valid = 1; req_addr = 8'h03; req_wdata = 8'h99; req_read = 0; req_write = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1 || valM !== 8'h33 || req_ready !== 0) begin
                errors++; $display("FAIL bp_hold%0d got vld=%b valM=%h rdy=%b, need 1 33 0", i, rsp_valid, valM, req_ready);
            end
        end
        @(posedge clk); #1; req_valid = 0;
        wait_rsp(v, e);
        checks++;
        if (v !== 8'h33 || e !== 0) begin errors++; $display("FAIL bp_rsp got %h/%b, need 33/0", v, e); end
        txn(8'h03, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h33) begin errors++; $display("FAIL bp_no_accept got %h, need 33", v); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] v; logic e;
        txn(8'h00, 8'h11, 0, 1, v, e);
        txn(8'h3F, 8'h3C, 0, 1, v, e);
        txn(8'h40, 8'hAA, 0, 1, v, e);
        checks++;
        if (v !== 8'h00 || e !== 1) begin errors++; $display("FAIL oor_wr got %h/%b, need 00/1", v, e); end
        txn(8'h00, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h11 || e !== 0) begin errors++; $display("FAIL oor_alias got %h/%b, need 11/0", v, e); end
        txn(8'hC0, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h00 || e !== 1) begin errors++; $display("FAIL oor_rd got %h/%b, need 00/1", v, e); end
        txn(8'h3F, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h3C || e !== 0) begin errors++; $display("FAIL top_word got %h/%b, need 3C/0", v, e); end
    endtask

    task automatic test_conflict();
        logic [7:0] v; logic e;
        txn(8'h02, 8'h22, 0, 1, v, e);
        txn(8'h02, 8'hEE, 1, 1, v, e);
        checks++;
        if (v !== 8'h00 || e !== 1) begin errors++; $display("FAIL conflict got %h/%b, need 00/1", v, e); end
        txn(8'h02, 8'hEE, 0, 0, v, e);
        checks++;
        if (v !== 8'h00 || e !== 0) begin errors++; $display("FAIL no_op got %h/%b, need 00/0", v, e); end
        txn(8'h02, 8'h00, 1, 0, v, e);
        checks++;
        if (v !== 8'h22 || e !== 0) begin errors++; $display("FAIL conflict_mem got %h/%b, need 22/0", v, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v; logic e;
        txn(8'h07, 8'h70, 0, 1, v, e);
        do_req(8'h07, 8'h77, 0, 1);
        #2 rst_n = 0; #1;
        checks++;
        if (rsp_valid !== 0 || req_ready !== 0) begin
            errors++; $display("FAIL rst_busy got vld=%b rdy=%b, need 0 0", rsp_valid, req_ready);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        do_req(8'h07, 8'h00, 1, 0);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1 || valM !== 8'h70) begin
            errors++; $display("FAIL rst_discard got vld=%b valM=%h, need 1 70", rsp_valid, valM);
        end
        rst_n = 0; #1;
        checks++;
        if (rsp_valid !== 0 || valM !== 8'h00 || dmem_error !== 0) begin
            errors++; $display("FAIL rst_resp got vld=%b valM=%h err=%b, need 0 00 0", rsp_valid, valM, dmem_error);
        end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_lat1();
        logic [7:0] va [6] = '{8'h10, 8'h11, 8'h10, 8'h11, 8'h10, 8'h50};
        logic [7:0] vw [6] = '{8'hA1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       vr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] ev [6] = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hA1, 8'h00};
        logic       ee [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            bit acc = 0;
            req_valid1 = 1; req_addr1 = va[k]; req_wdata1 = vw[k]; req_read1 = vr[k]; req_write1 = !vr[k];
            for (int i = 0; i < 20 && !acc; i++) begin
                @(negedge clk); acc = req_ready1;
                @(posedge clk); #1;
            end
            req_valid1 = 0; req_addr1 = 8'hFF;
            checks++;
            if (!acc || rsp_valid1 !== 1 || valM1 !== ev[k] || dmem_error1 !== ee[k]) begin
                errors++;
                $display("FAIL lat1_rsp%0d got acc=%b vld=%b valM=%h err=%b, need 1 1 %h %b", k, acc, rsp_valid1, valM1, dmem_error1, ev[k], ee[k]);
            end
            rsp_ready1 = 1; @(posedge clk); #1; rsp_ready1 = 0;
        end
`ifdef DMEM_PERF_CNT_EN
        checks++;
        if (rd_cnt1 !== 16'd3 || wr_cnt1 !== 16'd2 || err_cnt1 !== 16'd1) begin
            errors++; $display("FAIL perf_cnt got %0d %0d %0d, need 3 2 1", rd_cnt1, wr_cnt1, err_cnt1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_conflict();
        test_reset_mid();
        test_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
